// File: rtl/confreg_pkg.sv
// Shared definitions for the sram_confreg peripheral block: register offsets,
// CTRL bit positions and the byte-lane merge helper used by every RW register.
package confreg_pkg;

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_NUM     = 16'hF010;
    localparam logic [15:0] OFF_SWITCH  = 16'hF020;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_COMPARE = 16'hE004;
    localparam logic [15:0] OFF_CTRL    = 16'hE008;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_PENDING_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    // Replace each byte lane of old_val whose enable is set with the matching lane of new_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/confreg_timer.sv
// Free-running 32-bit timer with compare match, sticky pending flag and a
// registered interrupt output. Bus writes arrive already decoded per register.
module confreg_timer
    import confreg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  timer_we,
    input  logic [3:0]  compare_we,
    input  logic        ctrl_we,
    input  logic [31:0] wdata,
    output logic [31:0] timer,
    output logic [31:0] compare,
    output logic [31:0] ctrl,
    output logic        timer_irq
);

    logic [31:0] timer_reg, timer_next;
    logic [31:0] compare_reg, compare_next;
    logic        en_reg, en_next;
    logic        irq_en_reg, irq_en_next;
    logic        pending_reg, pending_next;
    logic        irq_reg, irq_next;
    logic        match;

    // Next-state logic: a bus write to TIMER takes priority over counting,
    // and a compare match beats a same-cycle write-1-to-clear of pending.
    always_comb begin
        timer_next   = timer_reg;
        compare_next = compare_reg;
        en_next      = en_reg;
        irq_en_next  = irq_en_reg;
        pending_next = pending_reg;
        match        = en_reg && (timer_reg == compare_reg);

        if (|timer_we)
            timer_next = byte_merge(timer_reg, wdata, timer_we);
        else if (en_reg)
            timer_next = timer_reg + 32'd1;

        if (|compare_we)
            compare_next = byte_merge(compare_reg, wdata, compare_we);

        if (ctrl_we) begin
            en_next     = wdata[CTRL_EN_BIT];
            irq_en_next = wdata[CTRL_IRQ_EN_BIT];
            if (wdata[CTRL_PENDING_BIT]) pending_next = 1'b0;
        end
        if (match) pending_next = 1'b1;

        // The interrupt flop tracks the pending/enable state being loaded this edge.
        irq_next = pending_next && irq_en_next;
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_reg   <= 32'h0;
            compare_reg <= 32'hFFFF_FFFF;
            en_reg      <= 1'b0;
            irq_en_reg  <= 1'b0;
            pending_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            timer_reg   <= timer_next;
            compare_reg <= compare_next;
            en_reg      <= en_next;
            irq_en_reg  <= irq_en_next;
            pending_reg <= pending_next;
            irq_reg     <= irq_next;
        end
    end

    assign timer     = timer_reg;
    assign compare   = compare_reg;
    assign ctrl      = {29'h0, irq_en_reg, pending_reg, en_reg};
    assign timer_irq = irq_reg;

endmodule

// File: rtl/sram_confreg.sv
// Peripheral register block on the sram slave interface: window decode,
// LED/NUM/switch registers, timer instance and one-cycle-latency read port.
module sram_confreg
    import confreg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1FAF_0000,
    parameter int          SW_WIDTH  = 8,
    parameter int          LED_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [31:0]          addr,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    input  logic [SW_WIDTH-1:0]  switch,
    output logic [LED_WIDTH-1:0] led,
    output logic [31:0]          num,
    output logic                 timer_irq
);

    logic        hit, wr, rd;
    logic [15:0] offset;
    logic [LED_WIDTH-1:0] led_reg;
    logic [31:0] num_reg;
    logic [SW_WIDTH-1:0]  sw_meta_reg, sw_sync_reg;
    logic [31:0] data_r_reg, data_r_next;
    logic [31:0] led_ext, sw_ext, led_merged;
    logic [31:0] timer_val, compare_val, ctrl_val;
    logic        unused_bits;

    // Byte offset within the window; the two low address bits are ignored.
    assign hit    = en && (addr[31:16] == BASE_ADDR[31:16]);
    assign offset = {addr[15:2], 2'b00};
    assign wr     = hit && (we != 4'h0);
    assign rd     = hit && (we == 4'h0);

    // Zero-extend the narrow registers to bus width.
    always_comb begin
        led_ext = '0;
        sw_ext  = '0;
        led_ext[LED_WIDTH-1:0] = led_reg;
        sw_ext[SW_WIDTH-1:0]   = sw_sync_reg;
    end

    assign led_merged  = byte_merge(led_ext, data_w, we);
    assign unused_bits = ^{addr[1:0], led_merged};

    confreg_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .timer_we   ((wr && offset == OFF_TIMER)   ? we : 4'h0),
        .compare_we ((wr && offset == OFF_COMPARE) ? we : 4'h0),
        .ctrl_we    (wr && offset == OFF_CTRL && we[0]),
        .wdata      (data_w),
        .timer      (timer_val),
        .compare    (compare_val),
        .ctrl       (ctrl_val),
        .timer_irq  (timer_irq)
    );

    // Read mux: value seen during the strobe cycle; unmapped offsets read 0.
    always_comb begin
        data_r_next = data_r_reg;
        if (rd) begin
            case (offset)
                OFF_LED:     data_r_next = led_ext;
                OFF_NUM:     data_r_next = num_reg;
                OFF_SWITCH:  data_r_next = sw_ext;
                OFF_TIMER:   data_r_next = timer_val;
                OFF_COMPARE: data_r_next = compare_val;
                OFF_CTRL:    data_r_next = ctrl_val;
                default:     data_r_next = 32'h0;
            endcase
        end
    end

    // LED/NUM registers, switch synchroniser and read data register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_reg     <= '0;
            num_reg     <= 32'h0;
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
            data_r_reg  <= 32'h0;
        end else begin
            sw_meta_reg <= switch;
            sw_sync_reg <= sw_meta_reg;
            data_r_reg  <= data_r_next;
            if (wr && offset == OFF_LED) led_reg <= led_merged[LED_WIDTH-1:0];
            if (wr && offset == OFF_NUM) num_reg <= byte_merge(num_reg, data_w, we);
        end
    end

    assign data_r = data_r_reg;
    assign led    = led_reg;
    assign num    = num_reg;

endmodule
